// File: rtl/rx_deserializer_if.sv
`default_nettype none
// ============================================================================
// Module   : rx_deserializer_if
// Brief    : Bundle of the strobe, control and word-output signals exchanged
//            between the bit-timing front end / consumer and rx_deserializer.
//            The master modport belongs to whoever drives the serial strobes
//            and acknowledges words; the slave modport belongs to the
//            deserializer itself.
// Revision : 1.0  initial release
// ============================================================================
interface rx_deserializer_if #(
    parameter int NUM_BITS = 8
);
    localparam int c_CNT_W = $clog2(NUM_BITS + 1);

    // Front end / consumer -> deserializer
    logic                shift_enable;
    logic                shift_stop;
    logic                serial_in;
    logic                sync_clr;
    logic                data_read;

    // Deserializer -> consumer
    logic [NUM_BITS-1:0] parallel_out;
    logic [NUM_BITS-1:0] rcv_data;
    logic                data_ready;
    logic                overrun;
    logic [c_CNT_W-1:0]  bit_count;

    modport master (
        output shift_enable,
        output shift_stop,
        output serial_in,
        output sync_clr,
        output data_read,
        input  parallel_out,
        input  rcv_data,
        input  data_ready,
        input  overrun,
        input  bit_count
    );

    modport slave (
        input  shift_enable,
        input  shift_stop,
        input  serial_in,
        input  sync_clr,
        input  data_read,
        output parallel_out,
        output rcv_data,
        output data_ready,
        output overrun,
        output bit_count
    );
endinterface
`default_nettype wire

// File: rtl/rx_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : rx_deserializer
// Brief    : Parametrised serial-to-parallel receive stage. Shifts one bit
//            per qualified strobe, counts bits, latches every complete
//            NUM_BITS word into a holding register, raises data_ready until
//            the consumer acknowledges, and flags overrun when a word lands
//            on top of an unread one.
// Revision : 1.0  initial release
// ============================================================================
module rx_deserializer #(
    parameter int   NUM_BITS  = 8,     // word width, 2..32
    parameter bit   SHIFT_MSB = 1'b0,  // 1: MSB-first line, 0: LSB-first line
    parameter logic IDLE_VAL  = 1'b1   // fill value of the shift register
) (
    input  wire logic          clk,
    input  wire logic          rst,
    rx_deserializer_if.slave   rx_bus
);
    localparam int                c_CNT_W = $clog2(NUM_BITS + 1);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(NUM_BITS - 1);
    localparam logic [c_CNT_W-1:0] c_ONE  = c_CNT_W'(1);
    localparam logic [NUM_BITS-1:0] c_IDLE_FILL = {NUM_BITS{IDLE_VAL}};

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [NUM_BITS-1:0] sr_q,   sr_d;
    logic [c_CNT_W-1:0]  cnt_q,  cnt_d;
    logic [NUM_BITS-1:0] rcv_q,  rcv_d;
    logic                rdy_q,  rdy_d;
    logic                ovr_q,  ovr_d;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic                w_acc;       // this cycle's bit is accepted
    logic                w_last;      // the accepted bit would be the final one
    logic                w_done;      // a word completes on this edge
    logic                w_read;      // acknowledge that actually consumes a word
    logic [NUM_BITS-1:0] w_sr_shift;  // register contents after taking serial_in

    // A strobe counts only when not held and not being aborted.
    assign w_acc  = rx_bus.shift_enable & ~rx_bus.shift_stop & ~rx_bus.sync_clr;
    // Full-width compare so the counter can never run past NUM_BITS-1.
    assign w_last = (cnt_q == c_LAST);
    assign w_done = w_acc & w_last;
    // An acknowledge with nothing pending has no effect.
    assign w_read = rx_bus.data_read & rdy_q;

    // Shift direction is fixed at elaboration; the new bit enters at the end
    // opposite to where the first bit of the word must finally sit.
    generate
        if (SHIFT_MSB) begin : g_shift_msb_first
            assign w_sr_shift = {sr_q[NUM_BITS-2:0], rx_bus.serial_in};
        end else begin : g_shift_lsb_first
            assign w_sr_shift = {rx_bus.serial_in, sr_q[NUM_BITS-1:1]};
        end
    endgenerate

    // Shift register and bit counter next state; abort beats shifting.
    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (rx_bus.sync_clr) begin
            sr_d  = c_IDLE_FILL;
            cnt_d = '0;
        end else if (w_acc) begin
            // The register is not cleared on completion: the next word simply
            // shifts over the old contents.
            sr_d  = w_sr_shift;
            cnt_d = w_last ? '0 : (cnt_q + c_ONE);
        end
    end

    // Holding register, ready and overrun next state.
    always_comb begin
        rcv_d = rcv_q;
        rdy_d = rdy_q;
        ovr_d = ovr_q;
        if (w_done) begin
            // The held word always takes the newest completed word, including
            // its final bit.
            rcv_d = w_sr_shift;
            rdy_d = 1'b1;
            // Landing on an unread, unacknowledged word is an overrun. If the
            // consumer acknowledges on this same edge nothing is lost, and the
            // overrun flag keeps its previous value.
            if (rdy_q && !rx_bus.data_read) begin
                ovr_d = 1'b1;
            end
        end else if (w_read) begin
            rdy_d = 1'b0;
            ovr_d = 1'b0;
        end
    end

    // Word-assembly state register, asynchronously returned to idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q  <= c_IDLE_FILL;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    // Output-word state register, asynchronously cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rcv_q <= '0;
            rdy_q <= 1'b0;
            ovr_q <= 1'b0;
        end else begin
            rcv_q <= rcv_d;
            rdy_q <= rdy_d;
            ovr_q <= ovr_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign rx_bus.parallel_out = sr_q;
    assign rx_bus.rcv_data     = rcv_q;
    assign rx_bus.data_ready   = rdy_q;
    assign rx_bus.overrun      = ovr_q;
    assign rx_bus.bit_count    = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_rx_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rx_deserializer
// Brief    : Self-checking bench for rx_deserializer. Three instances
//            (8-bit LSB-first, 8-bit MSB-first, 12-bit LSB-first) share one
//            clock and reset; a per-instance word-level model predicts every
//            output after each clock.
// Revision : 1.0  initial release
// ============================================================================
module tb_rx_deserializer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rx_deserializer_if #(.NUM_BITS(8))  if_a ();
    rx_deserializer_if #(.NUM_BITS(8))  if_b ();
    rx_deserializer_if #(.NUM_BITS(12)) if_c ();

    rx_deserializer #(.NUM_BITS(8),  .SHIFT_MSB(1'b0), .IDLE_VAL(1'b1)) u_a (
        .clk(clk), .rst(rst), .rx_bus(if_a.slave));
    rx_deserializer #(.NUM_BITS(8),  .SHIFT_MSB(1'b1), .IDLE_VAL(1'b1)) u_b (
        .clk(clk), .rst(rst), .rx_bus(if_b.slave));
    rx_deserializer #(.NUM_BITS(12), .SHIFT_MSB(1'b0), .IDLE_VAL(1'b1)) u_c (
        .clk(clk), .rst(rst), .rx_bus(if_c.slave));

    int checks = 0;
    int errors = 0;

    // Reference model: the line is seen as a bit stream; the register shows
    // the last N bits received, arranged by line order.
    int          nb     [3] = '{8, 8, 12};
    bit          msb1st [3] = '{1'b0, 1'b1, 1'b0};
    logic [31:0] m_sr   [3];
    int          m_cnt  [3];
    logic [31:0] m_rcv  [3];
    logic        m_rdy  [3];
    logic        m_ovr  [3];

    function automatic logic [31:0] mask_of(int d);
        return (32'd1 << nb[d]) - 32'd1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            m_sr[d]  = mask_of(d);
            m_cnt[d] = 0;
            m_rcv[d] = 32'd0;
            m_rdy[d] = 1'b0;
            m_ovr[d] = 1'b0;
        end
    endtask

    task automatic model_step(int d, bit en, bit stop, bit sin, bit clr, bit rd);
        bit accept;
        bit done;
        accept = en && !stop && !clr;
        done   = accept && (m_cnt[d] == nb[d] - 1);
        if (clr) begin
            m_sr[d]  = mask_of(d);
            m_cnt[d] = 0;
        end else if (accept) begin
            if (msb1st[d]) m_sr[d] = ((m_sr[d] << 1) | 32'(sin)) & mask_of(d);
            else           m_sr[d] = (m_sr[d] >> 1) | (32'(sin) << (nb[d] - 1));
            m_cnt[d] = (m_cnt[d] + 1) % nb[d];
        end
        if (done) begin
            m_rcv[d] = m_sr[d];
            if (m_rdy[d] && !rd) m_ovr[d] = 1'b1;
            m_rdy[d] = 1'b1;
        end else if (rd && m_rdy[d]) begin
            m_rdy[d] = 1'b0;
            m_ovr[d] = 1'b0;
        end
    endtask

    function automatic logic [31:0] get_par(int d);
        case (d)
            0:       return 32'(if_a.parallel_out);
            1:       return 32'(if_b.parallel_out);
            default: return 32'(if_c.parallel_out);
        endcase
    endfunction
    function automatic logic [31:0] get_rcv(int d);
        case (d)
            0:       return 32'(if_a.rcv_data);
            1:       return 32'(if_b.rcv_data);
            default: return 32'(if_c.rcv_data);
        endcase
    endfunction
    function automatic logic [31:0] get_cnt(int d);
        case (d)
            0:       return 32'(if_a.bit_count);
            1:       return 32'(if_b.bit_count);
            default: return 32'(if_c.bit_count);
        endcase
    endfunction
    function automatic logic get_rdy(int d);
        case (d)
            0:       return if_a.data_ready;
            1:       return if_b.data_ready;
            default: return if_c.data_ready;
        endcase
    endfunction
    function automatic logic get_ovr(int d);
        case (d)
            0:       return if_a.overrun;
            1:       return if_b.overrun;
            default: return if_c.overrun;
        endcase
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(int d, string tag);
        chk($sformatf("%s.d%0d.parallel_out", tag, d), get_par(d), m_sr[d]);
        chk($sformatf("%s.d%0d.rcv_data", tag, d),     get_rcv(d), m_rcv[d]);
        chk($sformatf("%s.d%0d.bit_count", tag, d),    get_cnt(d), 32'(m_cnt[d]));
        chk($sformatf("%s.d%0d.data_ready", tag, d),   32'(get_rdy(d)), 32'(m_rdy[d]));
        chk($sformatf("%s.d%0d.overrun", tag, d),      32'(get_ovr(d)), 32'(m_ovr[d]));
    endtask

    // Drive instance d; the other two see all-zero controls and stay idle.
    task automatic drive(int d, bit en, bit stop, bit sin, bit clr, bit rd);
        if_a.shift_enable = (d == 0) & en;  if_a.shift_stop = (d == 0) & stop;
        if_a.serial_in    = (d == 0) & sin; if_a.sync_clr   = (d == 0) & clr;
        if_a.data_read    = (d == 0) & rd;
        if_b.shift_enable = (d == 1) & en;  if_b.shift_stop = (d == 1) & stop;
        if_b.serial_in    = (d == 1) & sin; if_b.sync_clr   = (d == 1) & clr;
        if_b.data_read    = (d == 1) & rd;
        if_c.shift_enable = (d == 2) & en;  if_c.shift_stop = (d == 2) & stop;
        if_c.serial_in    = (d == 2) & sin; if_c.sync_clr   = (d == 2) & clr;
        if_c.data_read    = (d == 2) & rd;
    endtask

    // One clock cycle: drive at the falling edge, model the rising edge,
    // compare at the next falling edge.
    task automatic step(int d, bit en, bit stop, bit sin, bit clr, bit rd, string tag);
        drive(d, en, stop, sin, clr, rd);
        @(posedge clk);
        model_step(d, en, stop, sin, clr, rd);
        @(negedge clk);
        check_all(d, tag);
    endtask

    // Send one whole word in line order for instance d.
    task automatic send_word(int d, logic [31:0] w, bit rd_last, string tag);
        for (int i = 0; i < nb[d]; i++) begin
            bit b;
            b = msb1st[d] ? w[nb[d] - 1 - i] : w[i];
            step(d, 1'b1, 1'b0, b, 1'b0, rd_last && (i == nb[d] - 1), tag);
        end
    endtask

    initial begin
        drive(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        model_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) check_all(d, "reset");
        rst = 1'b0;

        // Test 1: 0xA5 LSB-first on the 8-bit instance.
        for (int i = 0; i < 7; i++) step(0, 1'b1, 1'b0, 1'(8'hA5 >> i), 1'b0, 1'b0, "t1_bits");
        chk("t1.ready_before_last", 32'(get_rdy(0)), 32'd0);
        step(0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "t1_last");
        chk("t1.rcv_data", get_rcv(0), 32'hA5);
        chk("t1.ready", 32'(get_rdy(0)), 32'd1);
        chk("t1.bit_count", get_cnt(0), 32'd0);
        step(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "t1_read");

        // Test 2: MSB-first 1,0,1,1,<held strobe>,0,0,1,0 -> 0xB2.
        step(1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "t2");
        step(1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "t2");
        step(1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "t2");
        step(1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "t2");
        step(1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "t2_stop");
        chk("t2.count_held", get_cnt(1), 32'd4);
        step(1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "t2");
        step(1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "t2");
        step(1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "t2");
        step(1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "t2");
        chk("t2.rcv_data", get_rcv(1), 32'hB2);
        step(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "t2_read");

        // Test 3: two unread words -> overrun; a read clears both flags.
        send_word(0, 32'h3C, 1'b0, "t3_w1");
        send_word(0, 32'h5A, 1'b0, "t3_w2");
        chk("t3.overrun", 32'(get_ovr(0)), 32'd1);
        chk("t3.rcv_data", get_rcv(0), 32'h5A);
        step(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "t3_read");
        chk("t3.ready_cleared", 32'(get_rdy(0)), 32'd0);
        chk("t3.overrun_cleared", 32'(get_ovr(0)), 32'd0);

        // Test 4: acknowledge on the final-bit edge of the second word.
        send_word(0, 32'h11, 1'b0, "t4_w1");
        send_word(0, 32'h22, 1'b1, "t4_w2");
        chk("t4.ready", 32'(get_rdy(0)), 32'd1);
        chk("t4.rcv_data", get_rcv(0), 32'h22);
        chk("t4.overrun", 32'(get_ovr(0)), 32'd0);
        step(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "t4_read");

        // Test 5: abort after 5 bits while a word is pending.
        send_word(0, 32'h0F, 1'b0, "t5_pending");
        for (int i = 0; i < 5; i++) step(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "t5_part");
        step(0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "t5_clr");
        chk("t5.bit_count", get_cnt(0), 32'd0);
        chk("t5.parallel_out", get_par(0), 32'hFF);
        chk("t5.ready_kept", 32'(get_rdy(0)), 32'd1);
        send_word(0, 32'h96, 1'b0, "t5_word");
        chk("t5.rcv_data", get_rcv(0), 32'h96);
        step(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "t5_read");

        // Test 6: asynchronous reset between edges, mid-word, with data pending.
        send_word(0, 32'h77, 1'b0, "t6_pending");
        for (int i = 0; i < 3; i++) step(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "t6_part");
        #2 rst = 1'b1;
        #1 model_reset();
        for (int d = 0; d < 3; d++) check_all(d, "t6_async_rst");
        @(negedge clk);
        rst = 1'b0;
        send_word(2, 32'hABC, 1'b0, "t6_n12");
        chk("t6.rcv_data_n12", get_rcv(2), 32'hABC);
        chk("t6.ready_n12", 32'(get_rdy(2)), 32'd1);
        step(2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "t6_read");

        // Randomized traffic on all three instances.
        for (int n = 0; n < 1500; n++) begin
            int d;
            d = int'($urandom_range(0, 2));
            step(d,
                 ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 9) == 0),
                 1'($urandom),
                 ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 9) < 2),
                 "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
